// File: rtl/div_top_mod_if.sv
// Start/done handshake and operand/result bundle for the repeated-subtraction divider.
interface div_top_mod_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, ain, bin,
    input  quotient, remainder, div_by_zero, busy, done
  );

  modport slave (
    input  start, ain, bin,
    output quotient, remainder, div_by_zero, busy, done
  );
endinterface

// File: rtl/div_top_mod.sv
// Unsigned divider by repeated subtraction: one subtract per clock while R>=D.
// Optional feature macro DIV_REG_OUT_EN: hold results in dedicated output registers.
module div_top_mod #(
  parameter int unsigned WIDTH = 16
) (
  input  logic         clk,
  input  logic         resetn,
  div_top_mod_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, d_q, q_q;
  logic             dbz_q;
  logic             finish;

  // Leaving ITER: divisor zero or remainder has dropped below the divisor.
  assign finish = (d_q == '0) || (r_q < d_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ITER;
      ITER:    if (finish)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == ITER);
    bus.done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q   <= '0;
      d_q   <= '0;
      q_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            r_q   <= bus.ain;
            d_q   <= bus.bin;
            q_q   <= '0;
            dbz_q <= 1'b0;
          end
        end
        ITER: begin
          if (d_q == '0) begin
            dbz_q <= 1'b1;
            q_q   <= '0;
          end else if (r_q >= d_q) begin
            r_q <= r_q - d_q;
            q_q <= q_q + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_REG_OUT_EN
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dbz_out_q;

  // Load on the ITER->DONE edge; the working registers still hold pre-edge
  // values, so the divide-by-zero result is formed here rather than read back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
    end else if (state_q == ITER && finish) begin
      quot_q    <= (d_q == '0) ? '0 : q_q;
      rem_q     <= r_q;
      dbz_out_q <= (d_q == '0);
    end
  end

  always_comb begin
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_out_q;
  end
`else
  always_comb begin
    bus.quotient    = q_q;
    bus.remainder   = r_q;
    bus.div_by_zero = dbz_q;
  end
`endif

endmodule

// File: tb/tb_div_top_mod.sv
// Scoreboard bench for div_top_mod: drivers queue expected results, a monitor checks each done pulse.
module tb_div_top_mod;

  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  div_top_mod_if #(.WIDTH(WIDTH)) bus ();

  div_top_mod #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int unsigned at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_quotient"}, bus.quotient, e.q);
        chk({e.name, "_remainder"}, bus.remainder, e.r);
        chk({e.name, "_div_by_zero"}, bus.div_by_zero, e.z);
        chk({e.name, "_done_cycle"}, cyc, e.at);
        chk({e.name, "_busy_excl"}, bus.busy, 0);
      end
    end
  end

  task automatic push(input string n, input int q, input int r, input bit z, input int unsigned at);
    exp_t e;
    e.name = n; e.q = 16'(q); e.r = 16'(r); e.z = z; e.at = at;
    sb.push_back(e);
  endtask

  // Single-cycle start; expected done edge is acceptance edge + quotient + 1.
  task automatic begin_op(input string n, input int a, input int b, input int q, input int r, input bit z);
    @(negedge clk);
    bus.ain = 16'(a); bus.bin = 16'(b); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    push(n, q, r, z, cyc + q + 1);
  endtask

  task automatic wait_done(input string n);
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    chk({n, "_timeout"}, 1, 0);
  endtask

  initial begin
    int unsigned d;
    bus.start = 1'b0; bus.ain = '0; bus.bin = '0;
    #12;
    chk("reset_quotient", bus.quotient, 0);
    chk("reset_remainder", bus.remainder, 0);
    chk("reset_dbz", bus.div_by_zero, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    @(negedge clk); resetn = 1'b1;

    begin_op("t1", 100, 7, 14, 2, 0);
    @(negedge clk); chk("t1_busy", bus.busy, 1);
    wait_done("t1");
    begin_op("t2", 5, 9, 0, 5, 0);       wait_done("t2");
    begin_op("t3", 1234, 0, 0, 1234, 1); wait_done("t3");
    begin_op("t2b", 65535, 65535, 1, 0, 0); wait_done("t2b");

    // Start held high across a completion: relaunch only from IDLE.
    @(negedge clk);
    bus.ain = 16'd40; bus.bin = 16'd40; bus.start = 1'b1;
    @(posedge clk); #1;
    push("t4a", 1, 0, 0, cyc + 2);
    wait_done("t4a");
    d = cyc;
    bus.ain = 16'd0; bus.bin = 16'd3;
    push("t4b", 0, 0, 0, d + 3);
    @(negedge clk); chk("t4_idle_not_busy", bus.busy, 0);
    @(negedge clk); chk("t4_relaunch_busy", bus.busy, 1);
    bus.start = 1'b0;
    wait_done("t4b");

    // Reset mid-division: no result expected.
    @(negedge clk);
    bus.ain = 16'd60000; bus.bin = 16'd3; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (100) @(negedge clk);
    resetn = 1'b0; #1;
    chk("t5_rst_quotient", bus.quotient, 0);
    chk("t5_rst_remainder", bus.remainder, 0);
    chk("t5_rst_dbz", bus.div_by_zero, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_done", bus.done, 0);
    @(negedge clk); resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_idle_after_reset", bus.busy, 0);
    begin_op("t5", 60000, 3, 20000, 0, 0); wait_done("t5");

    // Worst case, with stray starts while busy.
    begin_op("t6", 65535, 1, 65535, 0, 0);
    repeat (5) @(negedge clk);
    bus.ain = 16'd3; bus.bin = 16'd3; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (1000) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_done("t6");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
